// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: valid/ready input, N data bits, optional parity,
// 1 or 2 stop bits, fixed oversampling, plus an independent DFT scan chain.
module uart_tx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int SCAN_LEN   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done,
    output logic [2:0]           state,
    input  logic                 scan_enable,
    input  logic                 scan_in,
    output logic                 scan_out
);

    localparam int BAUD_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(OVERSAMPLE - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    localparam logic              HAS_PAR   = (PARITY != 32'sd0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t                state_r, state_s;
    logic [BAUD_W-1:0]     baud_r, baud_s;
    logic [BIT_W-1:0]      bit_r, bit_s;
    logic [DATA_BITS-1:0]  data_r, data_s;
    logic                  par_r, par_s;
    logic                  tx_r, tx_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
    logic                  baud_last_s;
    logic [SCAN_LEN-1:0]   chain_r;

    // Odd parity makes data+parity carry an odd number of ones.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        logic x;
        x = ^d;
        if (PARITY == 32'sd1) begin
            return ~x;
        end else begin
            return x;
        end
    endfunction

    assign tx_ready = (state_r == ST_IDLE) && !scan_enable;
    assign tx       = tx_r;
    assign busy     = busy_r;
    assign tx_done  = done_r;
    assign state    = state_r;
    assign scan_out = chain_r[SCAN_LEN-1];

    // Next-state and next-output logic; each bit change lands on the terminal baud edge.
    always_comb begin
        state_s     = state_r;
        baud_s      = baud_r;
        bit_s       = bit_r;
        data_s      = data_r;
        par_s       = par_r;
        tx_s        = tx_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        baud_last_s = (baud_r == BAUD_LAST);
        case (state_r)
            ST_IDLE: begin
                tx_s   = 1'b1;
                busy_s = 1'b0;
                if (tx_valid && tx_ready) begin
                    state_s = ST_START;
                    tx_s    = 1'b0;
                    busy_s  = 1'b1;
                    baud_s  = '0;
                    bit_s   = '0;
                    data_s  = tx_data;
                    par_s   = parity_bit(tx_data);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_last_s) begin
                    state_s = ST_DATA;
                    baud_s  = '0;
                    bit_s   = '0;
                    tx_s    = data_r[0];
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (baud_last_s) begin
                    baud_s = '0;
                    if (bit_r == DATA_LAST) begin
                        bit_s = '0;
                        if (HAS_PAR) begin
                            state_s = ST_PARITY;
                            tx_s    = par_r;
                        end else begin
                            state_s = ST_STOP;
                            tx_s    = 1'b1;
                        end
                    end else begin
                        bit_s  = bit_r + BIT_ONE;
                        data_s = {1'b0, data_r[DATA_BITS-1:1]};
                        tx_s   = data_r[1];
                    end
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            ST_PARITY: begin
                if (baud_last_s) begin
                    state_s = ST_STOP;
                    baud_s  = '0;
                    bit_s   = '0;
                    tx_s    = 1'b1;
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            ST_STOP: begin
                tx_s = 1'b1;
                if (baud_last_s) begin
                    baud_s = '0;
                    if (bit_r == STOP_LAST) begin
                        state_s = ST_DONE;
                        bit_s   = '0;
                        done_s  = 1'b1;
                    end else begin
                        bit_s = bit_r + BIT_ONE;
                    end
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                tx_s    = 1'b1;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                tx_s    = 1'b1;
                busy_s  = 1'b0;
                baud_s  = '0;
                bit_s   = '0;
            end
        endcase
    end

    // Functional registers; scan mode freezes them so a frame resumes where it stopped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            baud_r  <= '0;
            bit_r   <= '0;
            data_r  <= '0;
            par_r   <= 1'b0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (!scan_enable) begin
            state_r <= state_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            data_r  <= data_s;
            par_r   <= par_s;
            tx_r    <= tx_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end else begin
            state_r <= state_r;
            baud_r  <= baud_r;
            bit_r   <= bit_r;
            data_r  <= data_r;
            par_r   <= par_r;
            tx_r    <= tx_r;
            busy_r  <= busy_r;
            done_r  <= done_r;
        end
    end

    if (SCAN_LEN > 1) begin : g_chain
        // Scan shift register, shifting toward the MSB.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                chain_r <= '0;
            end else if (scan_enable) begin
                chain_r <= {chain_r[SCAN_LEN-2:0], scan_in};
            end else begin
                chain_r <= chain_r;
            end
        end
    end else begin : g_chain_one
        // Single-flop scan chain.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                chain_r <= '0;
            end else if (scan_enable) begin
                chain_r[0] <= scan_in;
            end else begin
                chain_r <= chain_r;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: five configurations checked cycle by cycle against a
// frame model built from the serial framing rules.
module tb_uart_tx_cfg;

    localparam int ND = 5;
    localparam int DB [ND] = '{8, 8, 8, 5, 9};
    localparam int OS [ND] = '{16, 16, 16, 4, 3};
    localparam int PB [ND] = '{0, 2, 1, 0, 1};
    localparam int SB [ND] = '{1, 1, 1, 2, 2};
    localparam int SL [ND] = '{8, 8, 8, 8, 1};

    logic clk = 1'b0;
    logic rst;
    logic [ND-1:0] valid;
    logic [ND-1:0] scan_en;
    logic [ND-1:0] scan_in;
    logic [ND-1:0][8:0] data_v;
    wire  [ND-1:0] tx_w, ready_w, busy_w, done_w, so_w;
    wire  [ND-1:0][2:0] st_v;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] chain_m [ND];
    bit exp_tx[$];
    int exp_st[$];

    always #5 clk = ~clk;

    uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1), .SCAN_LEN(8)) dut0 (
        .clk(clk), .rst(rst), .tx_valid(valid[0]), .tx_ready(ready_w[0]), .tx_data(data_v[0][7:0]),
        .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]), .state(st_v[0]),
        .scan_enable(scan_en[0]), .scan_in(scan_in[0]), .scan_out(so_w[0]));
    uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1), .SCAN_LEN(8)) dut1 (
        .clk(clk), .rst(rst), .tx_valid(valid[1]), .tx_ready(ready_w[1]), .tx_data(data_v[1][7:0]),
        .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]), .state(st_v[1]),
        .scan_enable(scan_en[1]), .scan_in(scan_in[1]), .scan_out(so_w[1]));
    uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1), .SCAN_LEN(8)) dut2 (
        .clk(clk), .rst(rst), .tx_valid(valid[2]), .tx_ready(ready_w[2]), .tx_data(data_v[2][7:0]),
        .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]), .state(st_v[2]),
        .scan_enable(scan_en[2]), .scan_in(scan_in[2]), .scan_out(so_w[2]));
    uart_tx_cfg #(.DATA_BITS(5), .OVERSAMPLE(4), .PARITY(0), .STOP_BITS(2), .SCAN_LEN(8)) dut3 (
        .clk(clk), .rst(rst), .tx_valid(valid[3]), .tx_ready(ready_w[3]), .tx_data(data_v[3][4:0]),
        .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]), .state(st_v[3]),
        .scan_enable(scan_en[3]), .scan_in(scan_in[3]), .scan_out(so_w[3]));
    uart_tx_cfg #(.DATA_BITS(9), .OVERSAMPLE(3), .PARITY(1), .STOP_BITS(2), .SCAN_LEN(1)) dut4 (
        .clk(clk), .rst(rst), .tx_valid(valid[4]), .tx_ready(ready_w[4]), .tx_data(data_v[4][8:0]),
        .tx(tx_w[4]), .busy(busy_w[4]), .tx_done(done_w[4]), .state(st_v[4]),
        .scan_enable(scan_en[4]), .scan_in(scan_in[4]), .scan_out(so_w[4]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int n, input bit v, input int s);
        for (int i = 0; i < n; i++) begin
            exp_tx.push_back(v);
            exp_st.push_back(s);
        end
    endtask

    // Expected line level and FSM phase for every cycle of one frame.
    task automatic build(input int d, input logic [8:0] w);
        int ones;
        bit p;
        exp_tx.delete();
        exp_st.delete();
        ones = 0;
        put(OS[d], 1'b0, 1);
        for (int i = 0; i < DB[d]; i++) begin
            ones += int'(w[i]);
            put(OS[d], w[i], 2);
        end
        if (PB[d] != 0) begin
            p = (PB[d] == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
            put(OS[d], p, 3);
        end
        put(SB[d] * OS[d], 1'b1, 4);
    endtask

    function automatic int frame_len(input int d);
        return (1 + DB[d] + ((PB[d] != 0) ? 1 : 0) + SB[d]) * OS[d];
    endfunction

    task automatic check_scan_out(input int d);
        chk("scan_out", 32'(so_w[d]), 32'(chain_m[d][SL[d]-1]));
    endtask

    // Called just after a falling edge; leaves at the falling edge of cycle F+2.
    task automatic send_frame(input int d, input logic [8:0] w, input bit hold,
                              input int scan_at, input logic [7:0] scan_word, input int abort_at);
        int f;
        bit b;
        build(d, w);
        f = exp_tx.size();
        #1;
        chk("ready_idle", 32'(ready_w[d]), 1);
        chk("tx_idle", 32'(tx_w[d]), 1);
        valid[d]  = 1'b1;
        data_v[d] = w;
        @(posedge clk);
        #1;
        if (!hold) valid[d] = 1'b0;
        data_v[d] = 9'($urandom);
        for (int k = 0; k < f; k++) begin
            @(negedge clk);
            chk("tx_bit", 32'(tx_w[d]), 32'(exp_tx[k]));
            chk("state", 32'(st_v[d]), 32'(exp_st[k]));
            chk("busy", 32'(busy_w[d]), 1);
            chk("ready_busy", 32'(ready_w[d]), 0);
            if (k == scan_at) begin
                check_scan_out(d);
                for (int s = 0; s < 8; s++) begin
                    b = scan_word[7-s];
                    scan_en[d] = 1'b1;
                    scan_in[d] = b;
                    @(negedge clk);
                    chain_m[d] = {chain_m[d][6:0], b};
                    check_scan_out(d);
                    chk("tx_frozen", 32'(tx_w[d]), 32'(exp_tx[k]));
                    chk("state_frozen", 32'(st_v[d]), 32'(exp_st[k]));
                    chk("ready_scan", 32'(ready_w[d]), 0);
                    chk("done_scan", 32'(done_w[d]), 0);
                end
                scan_en[d] = 1'b0;
                scan_in[d] = 1'b0;
            end
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                chk("rst_tx", 32'(tx_w[d]), 1);
                chk("rst_state", 32'(st_v[d]), 0);
                chk("rst_busy", 32'(busy_w[d]), 0);
                chk("rst_ready", 32'(ready_w[d]), 1);
                for (int i = 0; i < ND; i++) chain_m[i] = 8'h00;
                check_scan_out(d);
                valid[d] = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
        @(negedge clk);
        chk("done_pulse", 32'(done_w[d]), 1);
        chk("done_state", 32'(st_v[d]), 5);
        chk("done_busy", 32'(busy_w[d]), 1);
        chk("done_tx", 32'(tx_w[d]), 1);
        chk("done_ready", 32'(ready_w[d]), 0);
        @(negedge clk);
        chk("post_ready", 32'(ready_w[d]), 1);
        chk("post_busy", 32'(busy_w[d]), 0);
        chk("post_done", 32'(done_w[d]), 0);
        chk("post_state", 32'(st_v[d]), 0);
        chk("post_tx", 32'(tx_w[d]), 1);
    endtask

    // Scan shift while a word is offered in IDLE: nothing may be accepted.
    task automatic idle_scan(input int d);
        bit b;
        #1;
        b = 1'($urandom);
        scan_en[d] = 1'b1;
        scan_in[d] = b;
        valid[d]   = 1'b1;
        data_v[d]  = 9'($urandom);
        @(negedge clk);
        chain_m[d] = {chain_m[d][6:0], b};
        check_scan_out(d);
        chk("scan_idle_state", 32'(st_v[d]), 0);
        chk("scan_idle_tx", 32'(tx_w[d]), 1);
        chk("scan_idle_busy", 32'(busy_w[d]), 0);
        chk("scan_idle_ready", 32'(ready_w[d]), 0);
        scan_en[d] = 1'b0;
        scan_in[d] = 1'b0;
        valid[d]   = 1'b0;
    endtask

    initial begin
        int d;
        int sa;
        rst     = 1'b1;
        valid   = '0;
        scan_en = '0;
        scan_in = '0;
        data_v  = '0;
        for (int i = 0; i < ND; i++) chain_m[i] = 8'h00;
        #3;
        for (int i = 0; i < ND; i++) begin
            chk("reset_tx", 32'(tx_w[i]), 1);
            chk("reset_busy", 32'(busy_w[i]), 0);
            chk("reset_done", 32'(done_w[i]), 0);
            chk("reset_state", 32'(st_v[i]), 0);
            chk("reset_ready", 32'(ready_w[i]), 1);
            chk("reset_scan", 32'(so_w[i]), 0);
        end
        @(negedge clk);
        rst = 1'b0;

        send_frame(0, 9'h0A5, 1'b0, -1, 8'h00, -1);
        send_frame(1, 9'h007, 1'b0, -1, 8'h00, -1);
        send_frame(2, 9'h007, 1'b0, -1, 8'h00, -1);
        send_frame(3, 9'h01F, 1'b0, -1, 8'h00, -1);
        send_frame(0, 9'h000, 1'b1, -1, 8'h00, -1);
        send_frame(0, 9'h0FF, 1'b0, -1, 8'h00, -1);
        idle_scan(0);
        send_frame(0, 9'h0A5, 1'b0, 69, 8'hC3, -1);
        send_frame(0, 9'h05A, 1'b0, -1, 8'h00, 52);
        send_frame(0, 9'h03C, 1'b0, -1, 8'h00, -1);
        idle_scan(4);
        send_frame(4, 9'h1B3, 1'b0, 20, 8'h5A, -1);

        for (int r = 0; r < 14; r++) begin
            d  = int'($urandom_range(0, ND - 1));
            sa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, frame_len(d) - 1)) : -1;
            if ($urandom_range(0, 3) == 0) idle_scan(d);
            send_frame(d, 9'($urandom), 1'(r % 3 == 0), sa, 8'($urandom), -1);
            if (r % 3 == 0) send_frame(d, 9'($urandom), 1'b0, -1, 8'h00, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter with a valid/ready input handshake, configurable data width, oversampling ratio, parity mode and stop-bit count, plus a dedicated DFT scan chain. It sits between a byte/word producer (FIFO or CPU register) and the serial pad. It is the configurable generation of the fixed 8N1 transmitter.

## Interface
- DATA_BITS, 8, data bits per frame, legal 5..9
- OVERSAMPLE, 16, clk cycles per serial bit, legal 2..256
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, stop bits per frame, legal 1 or 2
- SCAN_LEN, 8, scan chain length, legal ≥1
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- tx_valid  in  1  producer has a word on tx_data
- tx_ready  out  1  block accepts a word this cycle; combinational, = (state==IDLE) && !scan_enable
- tx_data  in  DATA_BITS  word to send, sampled only on the accept edge
- tx  out  1  serial line, registered, idle high
- busy  out  1  high from the accept edge until DONE exits
- tx_done  out  1  one-cycle pulse, high during DONE
- state  out  3  FSM state: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, DONE=5
- scan_enable  in  1  scan shift mode
- scan_in  in  1  scan serial input
- scan_out  out  1  scan chain MSB

## Operation
- Reset (async): state=IDLE, tx=1, busy=0, tx_done=0, baud/bit counters=0, shift register=0, scan chain=0. This gives tx_ready=1 when scan_enable=0.
- Accept: tx_valid && tx_ready at a rising edge. On that edge: capture tx_data, tx<=0, busy<=1, baud_cnt<=0, state<=START.
- tx_valid without tx_ready is ignored. The producer holds tx_data until accepted. Changes to tx_data after accept do not affect the frame.
- Each serial bit lasts exactly OVERSAMPLE cycles. baud_cnt counts 0..OVERSAMPLE-1. At the terminal count the FSM advances and drives the next bit value on the same edge.
- START: tx=0. Then DATA.
- DATA: bits are sent LSB first; bit_cnt runs 0..DATA_BITS-1. After the last bit, go to PARITY if PARITY≠0, else STOP.
- PARITY: odd means the total ones in data+parity is odd. Even means the total is even. Then STOP.
- STOP: tx=1 for STOP_BITS*OVERSAMPLE cycles. Then DONE.
- DONE: one cycle. tx=1, tx_done=1, busy=1. Then IDLE, with busy=0 and tx_done=0.
- IDLE: tx=1.
- Illegal state encodings go to IDLE with tx=1 on the next edge.
- Scan mode (scan_enable=1):
  - The scan chain shifts {chain[SCAN_LEN-2:0], scan_in} every edge.
  - All functional registers (state, counters, tx, busy, shift register) hold.
  - tx_ready=0.
  - When scan_enable drops, the frame resumes exactly where it froze.
- Counter widths: baud_cnt is $clog2(OVERSAMPLE) bits; bit_cnt is $clog2(DATA_BITS) bits, minimum 1. No wrap beyond the terminal counts.

## Timing
- tx goes low at the accept edge. The start bit occupies cycles 1..OVERSAMPLE after accept.
- Frame length F = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) * OVERSAMPLE cycles. DONE is cycle F+1 after accept, and tx_ready rises in cycle F+2.
- Minimum gap between frames is stop time + 2 idle-high cycles (DONE + the accept cycle in IDLE).
- Simultaneous events:
  - scan_enable=1 with tx_valid=1 in IDLE: no accept.
  - scan_enable=1 with a terminal baud count: the advance is deferred until scan_enable=0.
- Reset mid-frame: tx returns to 1 asynchronously and the FSM is in IDLE. A new frame restarts cleanly on the first accept after reset releases.

## Test plan
- Default params, accept 0xA5: tx is 0,1,0,1,0,0,1,0,1,1, each held 16 cycles (160 total). tx_done pulses in cycle 161. busy falls after DONE. tx_ready is high in cycle 162.
- PARITY=2, accept 0x07: parity bit = 1. With PARITY=1, same data: parity bit = 0. Frame = 176 cycles.
- DATA_BITS=5, STOP_BITS=2, OVERSAMPLE=4, accept 0x1F: start for 4 cycles, five 1s for 20 cycles, stop high for 8 cycles. tx_done in cycle 33.
- Back-to-back with tx_valid held high, words 0x00 then 0xFF: the second accept occurs 2 cycles after the first stop period ends. No word is lost or repeated, and tx_data changes during frame 1 are ignored.
- Mid-DATA (bit 3), assert scan_enable for 8 cycles while shifting 0xC3 in MSB first. Required response:
  - scan_out shows the prior chain contents, then 0xC3 appears after 8 more shifts.
  - tx, state and counters are frozen.
  - The frame completes with total active length 160+8 cycles.
- Assert rst during DATA of 0x5A: tx=1, state=0 and busy=0 immediately. After release, 0x3C transmits correctly.
